// File: rtl/seq_left_shift.sv
// Multi-cycle 8-bit left shifter with a valid/ready handshake on both sides.
// Define LSHIFT_ROTATE_EN to rotate bit 7 into bit 0 instead of zero-filling.
module seq_left_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data,
  input  logic [2:0] shift,
  output logic [7:0] shout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_work;
  logic [7:0] w_step;
  logic [2:0] r_cnt;
  logic       w_accept;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SHIFT);
  assign out_valid = (r_state == DONE);
  assign shout     = r_work;
  assign w_accept  = in_valid && in_ready;

`ifdef LSHIFT_ROTATE_EN
  assign w_step = {r_work[6:0], r_work[7]};
`else
  assign w_step = {r_work[6:0], 1'b0};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = (shift != 3'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        w_next = (r_cnt == 3'd1) ? DONE : SHIFT;
      end
      DONE: begin
        w_next = out_ready ? IDLE : DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The working register keeps its value after DONE so shout stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= 8'h00;
      r_cnt  <= 3'd0;
    end else if (w_accept) begin
      r_work <= data;
      r_cnt  <= shift;
    end else if (busy) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_seq_left_shift.sv
// Self-checking bench for seq_left_shift against a behavioural shift model.
// Build with LSHIFT_ROTATE_EN defined to check the rotate variant.
module tb_seq_left_shift;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic [2:0] shift;
  logic [7:0] shout;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_pass;
  int n_total;

  seq_left_shift dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .shift     (shift),
    .shout     (shout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int n);
    logic [15:0] w;
`ifdef LSHIFT_ROTATE_EN
    w = {d, d} << n;
    return w[15:8];
`else
    w = {8'h00, d} << n;
    return w[7:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // One full transaction; returns observed latency/busy count and result.
  task automatic do_op(input logic [7:0] d, input logic [2:0] n,
                       input bit rdy_early, output int lat,
                       output int busy_cnt, output logic [7:0] res);
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL op_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    in_valid  = 1'b1;
    data      = d;
    shift     = n;
    out_ready = rdy_early;
    @(posedge clk);
    lat = 1;
    busy_cnt = 0;
    @(negedge clk);
    in_valid = 1'b0;
    data     = 8'($urandom);
    shift    = 3'($urandom);
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = shout;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL op_timeout: out_valid never rose after %0d edges", lat);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL op_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
    n_total++;
    if (shout !== res) $display("FAIL op_hold_after: got %0h expected %0h", shout, res);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data = 8'h00;
    shift = 3'd0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({shout, out_valid, busy, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: shout=%0h ov=%b busy=%b ir=%b expected 0/0/0/1",
               shout, out_valid, busy, in_ready);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [7:0] r;
`ifdef LSHIFT_ROTATE_EN
    do_op(8'hB5, 3'd3, 1'b1, lat, bc, r);
    chk("b5_rot3_res", 32'(r), 32'hAD);
`else
    do_op(8'hB5, 3'd3, 1'b1, lat, bc, r);
    chk("b5_sh3_res", 32'(r), 32'hA8);
`endif
    chk("b5_sh3_lat", lat, 4);
    chk("b5_sh3_busy", bc, 3);
  endtask

  task automatic test_zero_shift();
    int lat, bc;
    logic [7:0] r;
    do_op(8'h5A, 3'd0, 1'b0, lat, bc, r);
    chk("sh0_res", 32'(r), 32'h5A);
    chk("sh0_lat", lat, 1);
    chk("sh0_busy", bc, 0);
  endtask

  task automatic test_max_shift();
    int lat, bc;
    logic [7:0] r;
    do_op(8'h01, 3'd7, 1'b0, lat, bc, r);
    chk("sh7_01_res", 32'(r), 32'h80);
    chk("sh7_01_lat", lat, 8);
    do_op(8'hFE, 3'd7, 1'b0, lat, bc, r);
`ifdef LSHIFT_ROTATE_EN
    chk("rot7_fe_res", 32'(r), 32'h7F);
`else
    chk("sh7_fe_res", 32'(r), 32'h00);
`endif
    chk("sh7_fe_lat", lat, 8);
  endtask

  task automatic test_rotate();
`ifdef LSHIFT_ROTATE_EN
    int lat, bc;
    logic [7:0] r;
    do_op(8'h80, 3'd1, 1'b0, lat, bc, r);
    chk("rot_80_1_res", 32'(r), 32'h01);
    chk("rot_80_1_lat", lat, 2);
`endif
  endtask

  task automatic test_hold();
    logic [7:0] exp;
    int guard;
    exp = ref_shift(8'h3C, 2);
    @(negedge clk);
    in_valid = 1'b1;
    data = 8'h3C;
    shift = 3'd2;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    data = 8'hFF;
    shift = 3'd1;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (shout !== exp || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL hold_cycle%0d: shout=%0h ir=%b ov=%b expected %0h/0/1",
                 i, shout, in_ready, out_valid, exp);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || shout !== exp)
      $display("FAIL hold_release: ir=%b ov=%b shout=%0h expected 1/0/%0h",
               in_ready, out_valid, shout, exp);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    data = 8'h81;
    shift = 3'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL abort_pre_busy: got %b expected 1", busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({shout, out_valid, busy, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL abort_state: shout=%0h ov=%b busy=%b ir=%b expected 0/0/0/1",
               shout, out_valid, busy, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] r, d;
    logic [2:0] n;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      n = 3'($urandom_range(7, 0));
      do_op(d, n, 1'($urandom), lat, bc, r);
      n_total++;
      if (r !== ref_shift(d, int'(n)) || lat != int'(n) + 1 || bc != int'(n))
        $display("FAIL rand%0d d=%0h n=%0d: res=%0h lat=%0d busy=%0d expected %0h/%0d/%0d",
                 i, d, n, r, lat, bc, ref_shift(d, int'(n)), n + 1, n);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_zero_shift();
    test_max_shift();
    test_rotate();
    test_hold();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
